// File: rtl/store_pkg.sv
// Shared types and constants for the MEM-stage store buffer.
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;
    localparam logic [3:0] BE_B0  = 4'b0001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    // Overwrite only the byte lanes selected by be.
    function automatic logic [31:0] merge_data(input logic [31:0] old_d,
                                               input logic [31:0] new_d,
                                               input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_d & ~mask) | (new_d & mask);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Narrows register data to the addressed byte lanes and flags illegal size/alignment.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [3:0]  be_o,
    output logic        illegal_o
);

    always_comb begin
        data_o    = data_i;
        be_o      = 4'b0000;
        illegal_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                data_o = {4{data_i[7:0]}};
                be_o   = BE_B0 << lane_i;
            end
            SZ_HALF: begin
                data_o    = {2{data_i[15:0]}};
                be_o      = lane_i[1] ? BE_HI : BE_LO;
                illegal_o = lane_i[0];
            end
            SZ_WORD: begin
                be_o      = BE_ALL;
                illegal_o = (lane_i != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store queue with byte-lane narrowing and a req/ack drain port to data memory.
// Define STORE_MERGE_EN to let same-word stores merge into the not-yet-presented tail.
module store_buffer
    import store_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             st_valid_i,
    input  logic [1:0]       st_size_i,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      st_data_i,
    output logic             st_ready_o,
    output logic             misalign_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_ack_i,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    state_e           state_q;
    logic             mem_req_q, misalign_q;
    logic [31:0]      mem_addr_q, mem_data_q;
    logic [3:0]       mem_be_q;

    logic [31:0]      al_data;
    logic [3:0]       al_be;
    logic             al_illegal;
    logic [PTR_W-1:0] tail_idx, load_idx;
    logic             full, merge_hit, accept, push, merge, pop;

    store_lane_align u_align (
        .size_i    (st_size_i),
        .lane_i    (st_addr_i[1:0]),
        .data_i    (st_data_i),
        .data_o    (al_data),
        .be_o      (al_be),
        .illegal_o (al_illegal)
    );

    assign tail_idx = wr_ptr_q - PTR_W'(1);
    assign full     = (count_q == CNT_W'(DEPTH));

`ifdef STORE_MERGE_EN
    // Tail must not be the presented head, nor the entry about to be loaded this edge.
    assign merge_hit = st_valid_i && !al_illegal && (count_q > CNT_W'(1))
                     && (fifo_q[tail_idx].waddr == st_addr_i[31:2])
                     && !((state_q == S_REQ) && mem_ack_i && (count_q == CNT_W'(2)));
`else
    assign merge_hit = 1'b0;
`endif

    assign st_ready_o = !full || merge_hit;
    assign accept     = st_valid_i && st_ready_o;
    assign push       = accept && !al_illegal && !merge_hit;
    assign merge      = accept && merge_hit;
    assign pop        = (state_q == S_REQ) && mem_ack_i;
    assign load_idx   = (state_q == S_IDLE) ? rd_ptr_q : rd_ptr_q + PTR_W'(1);

    // Entry storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{waddr: st_addr_i[31:2], data: al_data, be: al_be};
        end else if (merge) begin
            fifo_q[tail_idx].be   <= fifo_q[tail_idx].be | al_be;
            fifo_q[tail_idx].data <= merge_data(fifo_q[tail_idx].data, al_data, al_be);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
            misalign_q <= accept && al_illegal;
        end
    end

    // Drain FSM: holds the presented entry until acked, then chains the next head.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_be_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {fifo_q[load_idx].waddr, 2'b00};
                        mem_data_q <= fifo_q[load_idx].data;
                        mem_be_q   <= fifo_q[load_idx].be;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        if (count_q > CNT_W'(1)) begin
                            mem_addr_q <= {fifo_q[load_idx].waddr, 2'b00};
                            mem_data_q <= fifo_q[load_idx].data;
                            mem_be_q   <= fifo_q[load_idx].be;
                        end else begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign misalign_o = misalign_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_be_o   = mem_be_q;
    assign empty_o    = (count_q == '0) && (state_q == S_IDLE);
    assign count_o    = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a reference queue of expected memory writes.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        st_valid_i = 1'b0;
    logic [1:0]  st_size_i = 2'b00;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        st_ready_o, misalign_o, mem_req_o, empty_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_be_o;
    logic [2:0]  count_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t sbq[$];
    int   mcnt = 0;
    bit   mreq = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .st_valid_i(st_valid_i), .st_size_i(st_size_i),
        .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_ready_o(st_ready_o), .misalign_o(misalign_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void narrow(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                   output bit legal, output logic [31:0] nd, output logic [3:0] be);
        legal = 1'b0; nd = d; be = 4'b0000;
        case (sz)
            2'b00: begin legal = 1'b1; nd = {4{d[7:0]}}; be = 4'b0001 << a[1:0]; end
            2'b01: begin legal = !a[0]; nd = {2{d[15:0]}}; be = a[1] ? 4'b1100 : 4'b0011; end
            2'b10: begin legal = (a[1:0] == 2'b00); be = 4'b1111; end
            default: legal = 1'b0;
        endcase
    endfunction

    // One clock: check handshake-side outputs before the edge, state outputs after it.
    task automatic tick();
        bit          legal, hit, acc, push, pop, ack;
        logic [31:0] nd, mask;
        logic [3:0]  nbe;
        exp_t        e;
        #1;
        ack = mem_ack_i;
        narrow(st_size_i, st_addr_i, st_data_i, legal, nd, nbe);
        hit = 0;
`ifdef STORE_MERGE_EN
        if (st_valid_i && legal && mcnt > 1 && sbq.size() > 0
            && sbq[sbq.size()-1].addr == {st_addr_i[31:2], 2'b00}
            && !(mreq && ack && mcnt == 2)) hit = 1;
`endif
        chk("st_ready", 32'(st_ready_o), 32'((mcnt < DEPTH) || hit));
        acc  = st_valid_i && ((mcnt < DEPTH) || hit);
        push = acc && legal && !hit;
        pop  = mreq && ack;
        if (pop) begin
            if (sbq.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else begin
                e = sbq.pop_front();
                chk("mem_addr", mem_addr_o, e.addr);
                chk("mem_data", mem_data_o, e.data);
                chk("mem_be", 32'(mem_be_o), 32'(e.be));
            end
        end
        if (acc && hit) begin
            e = sbq[sbq.size()-1];
            mask = {{8{nbe[3]}}, {8{nbe[2]}}, {8{nbe[1]}}, {8{nbe[0]}}};
            e.data = (e.data & ~mask) | (nd & mask);
            e.be = e.be | nbe;
            sbq[sbq.size()-1] = e;
        end
        if (push) sbq.push_back('{addr: {st_addr_i[31:2], 2'b00}, data: nd, be: nbe});
        @(posedge clk_i);
        #1;
        if (!mreq) begin
            if (mcnt > 0) mreq = 1;
        end else if (ack && mcnt - 1 <= 0) mreq = 0;
        mcnt = mcnt + int'(push) - int'(pop);
        chk("mem_req", 32'(mem_req_o), 32'(mreq));
        chk("count", 32'(count_o), 32'(mcnt));
        chk("misalign", 32'(misalign_o), 32'(acc && !legal));
        chk("empty", 32'(empty_o), 32'(mcnt == 0 && !mreq));
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_valid_i = 1'b1; st_size_i = sz; st_addr_i = a; st_data_i = d;
        tick();
        st_valid_i = 1'b0;
    endtask

    task automatic model_reset();
        mcnt = 0; mreq = 0; sbq.delete();
    endtask

    initial begin
        // Reset values
        #1;
        chk("rst_req", 32'(mem_req_o), 32'(0));
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_data", mem_data_o, 32'h0);
        chk("rst_be", 32'(mem_be_o), 32'(0));
        chk("rst_cnt", 32'(count_o), 32'(0));
        chk("rst_empty", 32'(empty_o), 32'(1));
        chk("rst_ready", 32'(st_ready_o), 32'(1));
        chk("rst_mis", 32'(misalign_o), 32'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Byte store to lane 3, acked one cycle after request
        st(2'b00, 32'h0000_1003, 32'hAABB_CC5A);
        tick();
        chk("sb_addr", mem_addr_o, 32'h0000_1000);
        chk("sb_be", 32'(mem_be_o), 32'(4'b1000));
        chk("sb_data", mem_data_o, 32'h5A5A_5A5A);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();

        // Halfword upper lanes, then a misaligned word
        st(2'b01, 32'h0000_2002, 32'h1234_BEEF);
        st(2'b10, 32'h0000_2001, 32'hDEAD_0001);
        chk("sh_be", 32'(mem_be_o), 32'(4'b1100));
        chk("sh_data", mem_data_o, 32'hBEEF_BEEF);
        tick();
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();

        // Fill to DEPTH with a fifth store pending
        for (int i = 0; i < 5; i++) begin
            st_valid_i = 1'b1; st_size_i = 2'b10;
            st_addr_i = 32'h0000_4000 + 32'(i * 4); st_data_i = 32'hC000_0000 + 32'(i);
            tick();
        end
        chk("full_cnt", 32'(count_o), 32'(4));
        chk("full_rdy", 32'(st_ready_o), 32'(0));
        // Ack and store in the same cycle while full: store waits one cycle
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
        st_valid_i = 1'b0;
        chk("refill_cnt", 32'(count_o), 32'(4));
        mem_ack_i = 1'b1;
        for (int i = 0; i < 8 && mcnt > 0; i++) tick();
        chk("drain_done", 32'(mcnt), 32'(0));
        mem_ack_i = 1'b0;
        tick();

        // Reset asserted mid-request discards everything
        st(2'b10, 32'h0000_6000, 32'h1);
        st(2'b10, 32'h0000_6004, 32'h2);
        st(2'b10, 32'h0000_6008, 32'h3);
        chk("pre_rst_req", 32'(mem_req_o), 32'(1));
        rst_i = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req_o), 32'(0));
        chk("mid_rst_cnt", 32'(count_o), 32'(0));
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Same-word byte stores behind a presented head
        st(2'b10, 32'h0000_5000, 32'h5555_5555);
        st(2'b00, 32'h0000_3000, 32'h0000_0011);
        st(2'b00, 32'h0000_3001, 32'h0000_0022);
        tick();
`ifdef STORE_MERGE_EN
        chk("merge_cnt", 32'(count_o), 32'(2));
`else
        chk("nomerge_cnt", 32'(count_o), 32'(3));
`endif
        mem_ack_i = 1'b1;
        for (int i = 0; i < 8 && mcnt > 0; i++) tick();
        chk("merge_drain", 32'(mcnt), 32'(0));
        mem_ack_i = 1'b0;
        tick();
        chk("sb_left", 32'(sbq.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
